// File: rtl/pito_dmem_ext_arbiter_if.sv
// Bus bundle between the data-memory EXT-port requesters, the arbiter and the SRAM port.
// The slave modport is the arbiter's view. The master modport is the requesters' and memory's view.
interface pito_dmem_ext_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = 4
) ();
    logic [NUM_REQ-1:0]            req_i;
    logic [NUM_REQ-1:0]            lock_i;
    logic [NUM_REQ-1:0]            we_i;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i;
    logic [NUM_REQ*BE_WIDTH-1:0]   be_i;
    logic [NUM_REQ-1:0]            gnt_o;
    logic [NUM_REQ-1:0]            rvalid_o;
    logic [DATA_WIDTH-1:0]         rdata_o;
    logic                          mem_req_o;
    logic                          mem_we_o;
    logic [ADDR_WIDTH-1:0]         mem_addr_o;
    logic [DATA_WIDTH-1:0]         mem_wdata_o;
    logic [BE_WIDTH-1:0]           mem_be_o;
    logic [DATA_WIDTH-1:0]         mem_rdata_i;
    logic                          locked_o;

    modport slave (
        input  req_i, lock_i, we_i, addr_i, wdata_i, be_i, mem_rdata_i,
        output gnt_o, rvalid_o, rdata_o, mem_req_o, mem_we_o, mem_addr_o,
               mem_wdata_o, mem_be_o, locked_o
    );

    modport master (
        output req_i, lock_i, we_i, addr_i, wdata_i, be_i, mem_rdata_i,
        input  gnt_o, rvalid_o, rdata_o, mem_req_o, mem_we_o, mem_addr_o,
               mem_wdata_o, mem_be_o, locked_o
    );
endinterface

// File: rtl/pito_dmem_ext_arbiter.sv
// Round-robin arbiter for the data-memory EXT port, with locked bursts capped at MAX_BURST beats.
// Handshake: a requester holds req_i until gnt_o (same cycle). rvalid_o follows each grant one cycle later.
module pito_dmem_ext_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = 4,
    parameter int MAX_BURST  = 16
) (
    input logic clk_i,
    input logic rst_ni,
    pito_dmem_ext_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

    typedef enum logic {ARB, LOCKED} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_q, rr_d, owner_q, owner_d;
    logic [CNT_W-1:0]   beat_q, beat_d;
    logic [NUM_REQ-1:0] gnt, gnt_q;
    logic               found;
    int                 j;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        beat_d  = beat_q;
        gnt     = '0;
        found   = 1'b0;
        j       = 0;
        case (state_q)
            ARB: begin
                for (int o = 0; o < NUM_REQ; o++) begin
                    j = (int'(rr_q) + o) % NUM_REQ;
                    if (!found && bus.req_i[j]) begin
                        found  = 1'b1;
                        gnt[j] = 1'b1;
                        rr_d   = IDX_W'((j + 1) % NUM_REQ);
                        if (bus.lock_i[j]) begin
                            owner_d = IDX_W'(j);
                            beat_d  = CNT_W'(1);
                            if (MAX_BURST > 1) state_d = LOCKED;
                        end
                    end
                end
            end
            LOCKED: begin
                // Only the owner may use the port; rr_q already points past it.
                gnt[owner_q] = bus.req_i[owner_q];
                if (bus.req_i[owner_q] && beat_q < MAX_CNT) beat_d = beat_q + CNT_W'(1);
                if (!bus.lock_i[owner_q] || (bus.req_i[owner_q] && beat_q >= LAST_CNT))
                    state_d = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB;
            rr_q    <= '0;
            owner_q <= '0;
            beat_q  <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            beat_q  <= beat_d;
            gnt_q   <= gnt;
        end
    end

    // Grants are forced low while reset is asserted so no access reaches the SRAM.
    assign bus.gnt_o     = rst_ni ? gnt : '0;
    assign bus.mem_req_o = |bus.gnt_o;
    assign bus.rvalid_o  = gnt_q;
    assign bus.rdata_o   = bus.mem_rdata_i;
    assign bus.locked_o  = (state_q == LOCKED);

    always_comb begin
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        bus.mem_be_o    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.gnt_o[i]) begin
                bus.mem_we_o    = bus.we_i[i];
                bus.mem_addr_o  = bus.addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                bus.mem_wdata_o = bus.wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                bus.mem_be_o    = bus.be_i[i*BE_WIDTH +: BE_WIDTH];
            end
        end
    end
endmodule

// File: tb/tb_pito_dmem_ext_arbiter.sv
// Directed bench for pito_dmem_ext_arbiter: a vector table for round-robin and burst behaviour,
// plus hand-written sequences for single access, forced release with idle gaps, and reset mid-burst.
module tb_pito_dmem_ext_arbiter;
    localparam int NR = 3;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int BW = 4;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    logic [DW-1:0] mem [0:4095];

    pito_dmem_ext_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) bus ();

    pito_dmem_ext_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .MAX_BURST(16)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    // SRAM model: one-cycle read latency, byte-enabled writes.
    always @(posedge clk_i) begin
        if (bus.mem_req_o) begin
            bus.mem_rdata_i <= mem[bus.mem_addr_o];
            if (bus.mem_we_o)
                for (int b = 0; b < BW; b++)
                    if (bus.mem_be_o[b]) mem[bus.mem_addr_o][b*8 +: 8] = bus.mem_wdata_o[b*8 +: 8];
        end
    end

    typedef struct {
        logic [NR-1:0] req;
        logic [NR-1:0] lock;
        logic [NR-1:0] we;
        logic [AW-1:0] a1;
        logic [NR-1:0] gnt;
        logic [NR-1:0] rv;
        logic          lk;
    } vec_t;

    vec_t vecs [22];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic [NR-1:0] req, input logic [NR-1:0] lock, input logic [NR-1:0] we,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        bus.req_i   = req;
        bus.lock_i  = lock;
        bus.we_i    = we;
        bus.addr_i  = {12'h030, a1, a0};
        bus.wdata_i = {32'hC000_0000, 32'hA000_0000 | {20'h0, a1}, 32'hB000_0000};
        bus.be_i    = '1;
    endtask

    task automatic do_reset();
        drive('0, '0, '0, 12'h020, 12'h000);
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        mem[12'h010] = 32'hDEAD_BEEF;
        bus.mem_rdata_i = '0;

        // Reset state with all requests asserted.
        drive(3'b111, 3'b000, 3'b000, 12'h020, 12'h040);
        #12;
        chk("rst_gnt", DW'(bus.gnt_o), 32'h0);
        chk("rst_mem_req", DW'(bus.mem_req_o), 32'h0);
        chk("rst_rvalid", DW'(bus.rvalid_o), 32'h0);
        chk("rst_locked", DW'(bus.locked_o), 32'h0);
        do_reset();

        // Single requester, no contention.
        @(negedge clk_i);
        drive(3'b001, 3'b000, 3'b000, 12'h010, 12'h040);
        #1;
        chk("t1_gnt", DW'(bus.gnt_o), 32'h1);
        chk("t1_mem_req", DW'(bus.mem_req_o), 32'h1);
        chk("t1_mem_addr", DW'(bus.mem_addr_o), 32'h010);
        chk("t1_mem_we", DW'(bus.mem_we_o), 32'h0);
        @(negedge clk_i);
        drive(3'b000, 3'b000, 3'b000, 12'h010, 12'h040);
        #1;
        chk("t1_rvalid", DW'(bus.rvalid_o), 32'h1);
        chk("t1_rdata", bus.rdata_o, 32'hDEAD_BEEF);
        chk("t1_idle_addr", DW'(bus.mem_addr_o), 32'h0);
        do_reset();

        // req, lock, we, a1, gnt, rvalid, locked
        vecs[0]  = '{3'b111, 3'b000, 3'b000, 12'h040, 3'b001, 3'b000, 1'b0};
        vecs[1]  = '{3'b111, 3'b000, 3'b000, 12'h040, 3'b010, 3'b001, 1'b0};
        vecs[2]  = '{3'b111, 3'b000, 3'b000, 12'h040, 3'b100, 3'b010, 1'b0};
        vecs[3]  = '{3'b111, 3'b000, 3'b000, 12'h040, 3'b001, 3'b100, 1'b0};
        vecs[4]  = '{3'b111, 3'b000, 3'b000, 12'h040, 3'b010, 3'b001, 1'b0};
        vecs[5]  = '{3'b111, 3'b000, 3'b000, 12'h040, 3'b100, 3'b010, 1'b0};
        vecs[6]  = '{3'b111, 3'b010, 3'b010, 12'h100, 3'b001, 3'b100, 1'b0};
        vecs[7]  = '{3'b111, 3'b010, 3'b010, 12'h100, 3'b010, 3'b001, 1'b0};
        vecs[8]  = '{3'b111, 3'b010, 3'b010, 12'h101, 3'b010, 3'b010, 1'b1};
        vecs[9]  = '{3'b111, 3'b010, 3'b010, 12'h102, 3'b010, 3'b010, 1'b1};
        vecs[10] = '{3'b111, 3'b010, 3'b010, 12'h103, 3'b010, 3'b010, 1'b1};
        vecs[11] = '{3'b101, 3'b000, 3'b000, 12'h040, 3'b000, 3'b010, 1'b1};
        vecs[12] = '{3'b101, 3'b000, 3'b000, 12'h040, 3'b100, 3'b000, 1'b0};
        vecs[13] = '{3'b101, 3'b000, 3'b000, 12'h040, 3'b001, 3'b100, 1'b0};
        vecs[14] = '{3'b111, 3'b010, 3'b010, 12'h104, 3'b010, 3'b001, 1'b0};
        vecs[15] = '{3'b101, 3'b010, 3'b000, 12'h040, 3'b000, 3'b010, 1'b1};
        vecs[16] = '{3'b101, 3'b010, 3'b000, 12'h040, 3'b000, 3'b000, 1'b1};
        vecs[17] = '{3'b101, 3'b010, 3'b000, 12'h040, 3'b000, 3'b000, 1'b1};
        vecs[18] = '{3'b111, 3'b010, 3'b010, 12'h105, 3'b010, 3'b000, 1'b1};
        vecs[19] = '{3'b111, 3'b010, 3'b010, 12'h106, 3'b010, 3'b010, 1'b1};
        vecs[20] = '{3'b101, 3'b000, 3'b000, 12'h040, 3'b000, 3'b010, 1'b1};
        vecs[21] = '{3'b101, 3'b000, 3'b000, 12'h040, 3'b100, 3'b000, 1'b0};

        for (int v = 0; v < 22; v++) begin
            @(negedge clk_i);
            drive(vecs[v].req, vecs[v].lock, vecs[v].we, 12'h020, vecs[v].a1);
            #1;
            chk($sformatf("v%0d_gnt", v), DW'(bus.gnt_o), DW'(vecs[v].gnt));
            chk($sformatf("v%0d_rvalid", v), DW'(bus.rvalid_o), DW'(vecs[v].rv));
            chk($sformatf("v%0d_locked", v), DW'(bus.locked_o), DW'(vecs[v].lk));
        end
        for (int a = 0; a < 7; a++)
            chk($sformatf("burst_mem_%0d", a), mem[12'h100 + a], 32'hA000_0100 + a);
        do_reset();

        // Forced release: one ARB beat, three idle cycles, 15 locked beats, then requester 0.
        @(negedge clk_i);
        drive(3'b010, 3'b010, 3'b000, 12'h020, 12'h050);
        #1;
        chk("fr_first_gnt", DW'(bus.gnt_o), 32'h2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            drive(3'b001, 3'b010, 3'b000, 12'h020, 12'h050);
            #1;
            chk($sformatf("fr_idle%0d_gnt", k), DW'(bus.gnt_o), 32'h0);
            chk($sformatf("fr_idle%0d_locked", k), DW'(bus.locked_o), 32'h1);
        end
        for (int k = 0; k < 15; k++) begin
            @(negedge clk_i);
            drive(3'b011, 3'b010, 3'b000, 12'h020, 12'h050);
            #1;
            chk($sformatf("fr_beat%0d_gnt", k + 2), DW'(bus.gnt_o), 32'h2);
        end
        @(negedge clk_i);
        #1;
        chk("fr_release_gnt", DW'(bus.gnt_o), 32'h1);
        chk("fr_release_locked", DW'(bus.locked_o), 32'h0);
        @(negedge clk_i);
        #1;
        chk("fr_rr_turn_gnt", DW'(bus.gnt_o), 32'h2);
        chk("fr_rr_turn_locked", DW'(bus.locked_o), 32'h0);

        // Reset mid-burst during a locked read.
        @(negedge clk_i);
        drive(3'b010, 3'b010, 3'b000, 12'h020, 12'h050);
        #1;
        chk("mr_pre_gnt", DW'(bus.gnt_o), 32'h2);
        chk("mr_pre_locked", DW'(bus.locked_o), 32'h1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mr_gnt", DW'(bus.gnt_o), 32'h0);
        chk("mr_rvalid", DW'(bus.rvalid_o), 32'h0);
        chk("mr_locked", DW'(bus.locked_o), 32'h0);
        chk("mr_mem_req", DW'(bus.mem_req_o), 32'h0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        drive(3'b111, 3'b000, 3'b000, 12'h020, 12'h050);
        #1;
        chk("mr_post_rvalid", DW'(bus.rvalid_o), 32'h0);
        chk("mr_post_gnt", DW'(bus.gnt_o), 32'h1);
        chk("mr_post_locked", DW'(bus.locked_o), 32'h0);
        @(negedge clk_i);
        #1;
        chk("mr_post_rvalid2", DW'(bus.rvalid_o), 32'h1);
        chk("mr_post_gnt2", DW'(bus.gnt_o), 32'h2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pito_dmem_ext_arbiter.md
Name: pito_dmem_ext_arbiter

Overview:
- Round-robin arbiter that shares the data-memory external port among NUM_REQ requesters: host loader, MVU result writer, debug/trace reader.
- Sits between the requesters and the EXT port of the dual-port data SRAM. The SRAM has 1-cycle read latency.
- Adds optional locked bursts so that one requester can own the port for several consecutive beats, with a hard beat limit to bound starvation.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_WIDTH, 12, word-address width of the data memory.
- DATA_WIDTH, 32, data width.
- BE_WIDTH, 4, byte-enable width (DATA_WIDTH/8).
- MAX_BURST, 16, maximum granted beats per lock tenure (2..256).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  NUM_REQ  per-requester access request.
- lock_i  in  NUM_REQ  per-requester burst-lock request.
- we_i  in  NUM_REQ  per-requester write enable.
- addr_i  in  NUM_REQ*ADDR_WIDTH  flattened word addresses; requester i occupies [i*ADDR_WIDTH +: ADDR_WIDTH].
- wdata_i  in  NUM_REQ*DATA_WIDTH  flattened write data.
- be_i  in  NUM_REQ*BE_WIDTH  flattened byte enables.
- gnt_o  out  NUM_REQ  one-hot grant, same cycle as the request.
- rvalid_o  out  NUM_REQ  one-hot response valid, one cycle after the grant.
- rdata_o  out  DATA_WIDTH  read data, broadcast to all requesters.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_WIDTH  memory address.
- mem_wdata_o  out  DATA_WIDTH  memory write data.
- mem_be_o  out  BE_WIDTH  memory byte enables.
- mem_rdata_i  in  DATA_WIDTH  memory read data, valid one cycle after mem_req_o.
- locked_o  out  1  high while in state LOCKED.

Behaviour:
- Reset (asynchronous, any state, including mid-burst):
  - state=ARB, rr_ptr=0, owner=0, beat_cnt=0.
  - rvalid_o=0 (registered).
  - gnt_o=0 and mem_req_o=0 while rst_ni is low.
  - mem_* data outputs may be X-free zeros.
  - Any access in flight when reset asserts is dropped: no rvalid_o follows it.
- Grant is combinational; at most one gnt_o bit is high per cycle.
  - mem_req_o = |gnt_o.
  - mem_we/addr/wdata/be are muxed from the granted requester. When nothing is granted they are zero.
- rvalid_o[i] is the registered gnt_o[i]. It is asserted for both reads and writes. rdata_o = mem_rdata_i and is meaningful only on read responses.
- Full throughput: back-to-back grants are allowed every cycle, with no bubble when switching requesters.
- State ARB:
  - Scan req_i starting at rr_ptr and wrapping modulo NUM_REQ; the first asserted requester k is granted.
  - On that grant, rr_ptr <= (k+1) mod NUM_REQ.
  - If lock_i[k] is also high: owner <= k, beat_cnt <= 1, and go to LOCKED. If MAX_BURST would be reached on this beat, stay in ARB.
- State LOCKED:
  - Only owner can be granted; other requests wait, even with the port idle.
  - owner's gnt = req_i[owner]. Each grant increments beat_cnt.
  - Idle cycles (req_i[owner]=0 while lock_i[owner]=1) keep the lock and do not count as beats.
  - Exit to ARB the cycle after lock_i[owner] falls. If lock_i and req_i fall together, that cycle is not granted.
  - Exit to ARB the cycle after the grant that makes beat_cnt==MAX_BURST (forced release).
  - rr_ptr stays at owner+1, so the next ARB cycle gives owner lowest priority.
  - After a forced release, owner may relock only after winning a fresh ARB scan.
- While LOCKED, lock_i on non-owners is ignored.
- beat_cnt width is clog2(MAX_BURST+1). It saturates and never wraps.
- locked_o = (state==LOCKED), registered.
- req_i must hold stable until granted. Requesters must keep req_i high until gnt_o; the arbiter does not queue requests.

Test Plan:
1. Single requester, no contention: req_i=3'b001, we=0, addr=0x010. gnt_o=001 in the same cycle; mem_addr_o=0x010; rvalid_o=001 next cycle with rdata_o equal to memory content.
2. Round robin: req_i=3'b111 held for 6 cycles after reset. Grants are 001,010,100,001,010,100 with no idle cycles, and the matching rvalid_o pattern is delayed by 1.
3. Locked burst: req1 with lock1 high for 4 writes while req0 and req2 are continuously high. gnt=010 for 4 cycles; lock1 drops; next grants are 100 then 001. Memory holds the 4 written words at the addresses given.
4. Forced release: MAX_BURST=16, req1 and lock1 held high indefinitely, req0 high. Exactly 16 consecutive gnt=010, then gnt=001 on cycle 17. Requester 1 is granted again only via a round-robin turn.
5. Lock with idle gaps: owner deasserts req for 3 cycles while keeping lock. No grant to others, beat_cnt unchanged, locked_o=1; the burst resumes afterwards.
6. Reset mid-burst: rst_ni low for 2 cycles during a LOCKED read. The following are all 0 immediately (asynchronously): gnt_o, rvalid_o, locked_o. The pending rvalid never appears. After release with req_i=111, the first grant is 001.
